// File: rtl/spi_master.sv
// SPI master: one DATA_W-bit full-duplex transfer per request, all four SPI modes,
// either bit order, programmable clock divider and optionally held chip select.
module spi_master #(
   parameter int DATA_W = 8,
   parameter int DIV_W  = 5,
   parameter int NUM_CS = 2,
   localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DIV_W-1:0]  divider,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   input  logic [CS_W-1:0]   cs_sel,
   input  logic              hold_cs,
   input  logic              cs_release,
   input  logic [DATA_W-1:0] data_tx,
   input  logic              txn_start,
   output logic              txn_ready,
   output logic [DATA_W-1:0] data_rx,
   output logic              rx_valid,
   output logic              busy,
   output logic              spi_clk,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic [NUM_CS-1:0] spi_cs_n
);

   typedef enum logic [1:0] {IDLE, SETUP, XFER, TEARDOWN} state_t;

   localparam int EC_W = $clog2(2*DATA_W + 1);
   localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2*DATA_W - 1);

   state_t            state_q;
   logic [DIV_W-1:0]  div_q, cnt_q;
   logic [EC_W-1:0]   edge_q;
   logic              cpol_q, cpha_q, lsb_q, hold_q;
   logic [DATA_W-1:0] tx_q, rx_q, data_rx_q;
   logic              sclk_q, mosi_q, rx_valid_q, busy_q;
   logic [NUM_CS-1:0] cs_n_q;

   logic              hp_end, sample_edge;
   logic [DATA_W-1:0] tx_ord_d, rx_next_d;

   function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
      return r;
   endfunction

   function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
      logic [NUM_CS-1:0] m;
      m = '1;
      for (int i = 0; i < NUM_CS; i++)
         if (sel == CS_W'(i)) m[i] = 1'b0;
      return m;
   endfunction

   // Shifting is always MSB-first internally; LSB-first words are reversed on the way in and out.
   assign tx_ord_d    = lsb_first ? bit_rev(data_tx) : data_tx;
   assign rx_next_d   = {rx_q[DATA_W-2:0], spi_miso};
   assign hp_end      = (cnt_q == div_q);
   // edge_q even means the edge about to happen is a leading edge
   assign sample_edge = (~edge_q[0]) ^ cpha_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         div_q      <= '0;
         cnt_q      <= '0;
         edge_q     <= '0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         lsb_q      <= 1'b0;
         hold_q     <= 1'b0;
         tx_q       <= '0;
         rx_q       <= '0;
         data_rx_q  <= '0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         cs_n_q     <= '1;
      end else begin
         rx_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               sclk_q <= cpol;
               if (txn_start) begin
                  state_q <= SETUP;
                  div_q   <= divider;
                  cnt_q   <= '0;
                  edge_q  <= '0;
                  cpol_q  <= cpol;
                  cpha_q  <= cpha;
                  lsb_q   <= lsb_first;
                  hold_q  <= hold_cs;
                  busy_q  <= 1'b1;
                  rx_q    <= '0;
                  cs_n_q  <= cs_decode(cs_sel);
                  if (cpha) begin
                     tx_q <= tx_ord_d;
                  end else begin
                     mosi_q <= tx_ord_d[DATA_W-1];
                     tx_q   <= tx_ord_d << 1;
                  end
               end else if (cs_release) begin
                  cs_n_q <= '1;
               end
            end
            SETUP: begin
               sclk_q <= cpol_q;
               if (hp_end) begin
                  cnt_q   <= '0;
                  state_q <= XFER;
               end else begin
                  cnt_q <= cnt_q + DIV_W'(1);
               end
            end
            XFER: begin
               if (hp_end) begin
                  cnt_q  <= '0;
                  sclk_q <= ~sclk_q;
                  edge_q <= edge_q + EC_W'(1);
                  if (sample_edge) begin
                     rx_q <= rx_next_d;
                  end else if (edge_q != LAST_EDGE) begin
                     mosi_q <= tx_q[DATA_W-1];
                     tx_q   <= tx_q << 1;
                  end
                  if (edge_q == LAST_EDGE) state_q <= TEARDOWN;
               end else begin
                  cnt_q <= cnt_q + DIV_W'(1);
               end
            end
            TEARDOWN: begin
               sclk_q <= cpol_q;
               if (hp_end) begin
                  cnt_q      <= '0;
                  state_q    <= IDLE;
                  busy_q     <= 1'b0;
                  rx_valid_q <= 1'b1;
                  data_rx_q  <= lsb_q ? bit_rev(rx_q) : rx_q;
                  if (!hold_q) cs_n_q <= '1;
               end else begin
                  cnt_q <= cnt_q + DIV_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign txn_ready = (state_q == IDLE);
   assign data_rx   = data_rx_q;
   assign rx_valid  = rx_valid_q;
   assign busy      = busy_q;
   assign spi_clk   = sclk_q;
   assign spi_mosi  = mosi_q;
   assign spi_cs_n  = cs_n_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: vector table of transfers with a completion scoreboard,
// plus hand sequences for held chip select, reset abort and a 16-bit / 3-CS instance.
module tb_spi_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [4:0] divider;
   logic       cpol, cpha, lsb_first, hold_cs, cs_release, txn_start;
   logic [0:0] cs_sel;
   logic [7:0] data_tx, data_rx;
   logic       txn_ready, rx_valid, busy, spi_clk, spi_mosi, spi_miso;
   logic [1:0] spi_cs_n;
   logic [1:0] miso_mode;

   assign spi_miso = (miso_mode == 2'd0) ? spi_mosi : (miso_mode == 2'd1);

   spi_master #(.DATA_W(8), .DIV_W(5), .NUM_CS(2)) dut (
      .clk(clk), .rst_n(rst_n), .divider(divider), .cpol(cpol), .cpha(cpha),
      .lsb_first(lsb_first), .cs_sel(cs_sel), .hold_cs(hold_cs), .cs_release(cs_release),
      .data_tx(data_tx), .txn_start(txn_start), .txn_ready(txn_ready), .data_rx(data_rx),
      .rx_valid(rx_valid), .busy(busy), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_cs_n(spi_cs_n));

   logic [4:0]  d2_divider;
   logic        d2_cpol, d2_cpha, d2_lsb, d2_hold, d2_rel, d2_start;
   logic [1:0]  d2_cs_sel;
   logic [15:0] d2_tx, d2_rx;
   logic        d2_ready, d2_valid, d2_busy, d2_clk, d2_mosi;
   logic [2:0]  d2_cs_n;

   spi_master #(.DATA_W(16), .DIV_W(5), .NUM_CS(3)) dut2 (
      .clk(clk), .rst_n(rst_n), .divider(d2_divider), .cpol(d2_cpol), .cpha(d2_cpha),
      .lsb_first(d2_lsb), .cs_sel(d2_cs_sel), .hold_cs(d2_hold), .cs_release(d2_rel),
      .data_tx(d2_tx), .txn_start(d2_start), .txn_ready(d2_ready), .data_rx(d2_rx),
      .rx_valid(d2_valid), .busy(d2_busy), .spi_clk(d2_clk), .spi_mosi(d2_mosi),
      .spi_miso(d2_mosi), .spi_cs_n(d2_cs_n));

   typedef struct {
      logic       cpol, cpha, lsb, hold;
      logic [4:0] div;
      logic [7:0] data;
      logic [1:0] miso;
      logic       cs;
      logic [7:0] exp_rx;
      int         exp_lat;
   } vec_t;

   typedef struct {
      logic [7:0] rx;
      int         acc;
      int         lat;
   } sb_t;

   sb_t  sbq[$];
   vec_t tbl[6];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = v[7-i];
      return r;
   endfunction

   // Completion monitor: every rx_valid pulse must match the oldest pending transfer.
   always @(negedge clk) begin
      if (rst_n && rx_valid) begin
         if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rx_unexpected: rx_valid with no pending transfer, data_rx=%0h (t=%0t)", data_rx, $time);
         end else begin
            sb_t e;
            e = sbq.pop_front();
            check("rx_data", {24'd0, data_rx}, {24'd0, e.rx});
            check("rx_latency", cyc - e.acc + 1, e.lat);
         end
      end
   end

   task automatic run_xfer(input vec_t v, input bit glitch, input bit rel);
      int         toggles, steps;
      logic       prev_clk;
      logic [7:0] cap;
      logic       cs_ok;
      logic [1:0] exp_cs;
      sb_t        e;
      cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb; hold_cs = v.hold;
      divider = v.div; data_tx = v.data; cs_sel = v.cs; miso_mode = v.miso;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("idle_clk", {31'd0, spi_clk}, {31'd0, v.cpol});
      exp_cs = 2'b11;
      exp_cs[v.cs] = 1'b0;
      txn_start = 1'b1;
      cs_release = rel;
      @(posedge clk); #1;
      txn_start = 1'b0;
      cs_release = 1'b0;
      e.rx = v.exp_rx; e.acc = cyc; e.lat = v.exp_lat;
      sbq.push_back(e);
      check("busy_on", {31'd0, busy}, 32'd1);
      check("ready_off", {31'd0, txn_ready}, 32'd0);
      check("cs_on", {30'd0, spi_cs_n}, {30'd0, exp_cs});
      prev_clk = spi_clk; toggles = 0; cap = '0; cs_ok = 1'b1; steps = 0;
      while (busy === 1'b1 && steps < 2000) begin
         if (glitch && steps == 5) begin
            txn_start = 1'b1; data_tx = ~v.data; cpol = ~v.cpol; cs_sel = ~v.cs;
         end
         if (glitch && steps == 6) txn_start = 1'b0;
         @(posedge clk); #1;
         steps++;
         if (busy === 1'b1 && spi_cs_n !== exp_cs) cs_ok = 1'b0;
         if (spi_clk !== prev_clk) begin
            toggles++;
            if ((spi_clk != v.cpol) != v.cpha) cap = {cap[6:0], spi_mosi};
            prev_clk = spi_clk;
         end
      end
      txn_start = 1'b0;
      check("done_in_budget", {31'd0, steps < 2000}, 32'd1);
      check("sclk_toggles", toggles, 32'd16);
      check("cs_during", {31'd0, cs_ok}, 32'd1);
      check("mosi_bits", {24'd0, (v.lsb ? rev8(cap) : cap)}, {24'd0, v.data});
      check("clk_end", {31'd0, spi_clk}, {31'd0, v.cpol});
      check("cs_after", {30'd0, spi_cs_n}, {30'd0, (v.hold ? exp_cs : 2'b11)});
      check("ready_back", {31'd0, txn_ready}, 32'd1);
      cpol = v.cpol;
      repeat (3) @(posedge clk);
      #1;
      check("mosi_hold", {31'd0, spi_mosi}, {31'd0, (v.lsb ? v.data[7] : v.data[0])});
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   steps, toggles;
      logic prev, cs_ok;

      //            cpol  cpha  lsb   hold  div    data   miso  cs    exp_rx lat
      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd1,  8'hA5, 2'd0, 1'b0, 8'hA5, 37};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  8'h01, 2'd1, 1'b0, 8'hFF, 19};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd2,  8'h3C, 2'd0, 1'b1, 8'h3C, 55};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 5'd0,  8'h96, 2'd0, 1'b1, 8'h96, 19};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd31, 8'h5A, 2'd2, 1'b0, 8'h00, 577};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd3,  8'hC3, 2'd1, 1'b1, 8'hFF, 73};

      rst_n = 1'b0;
      divider = '0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; hold_cs = 1'b0;
      cs_release = 1'b0; data_tx = '0; txn_start = 1'b0; cs_sel = '0; miso_mode = 2'd0;
      d2_divider = '0; d2_cpol = 1'b0; d2_cpha = 1'b0; d2_lsb = 1'b0; d2_hold = 1'b0;
      d2_rel = 1'b0; d2_start = 1'b0; d2_cs_sel = '0; d2_tx = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs", {30'd0, spi_cs_n}, 32'h3);
      check("rst_clk", {31'd0, spi_clk}, 32'd0);
      check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rxv", {31'd0, rx_valid}, 32'd0);
      check("rst_rx", {24'd0, data_rx}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_ready", {31'd0, txn_ready}, 32'd1);

      for (int i = 0; i < 6; i++) run_xfer(tbl[i], (i == 2), 1'b0);

      // Held CS across two back-to-back transfers, then explicit release.
      v = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 8'hA5, 2'd0, 1'b0, 8'hA5, 37};
      run_xfer(v, 1'b0, 1'b0);
      check("hold_gap_cs", {30'd0, spi_cs_n}, 32'h2);
      v.data = 8'h3C; v.exp_rx = 8'h3C;
      run_xfer(v, 1'b0, 1'b0);
      check("hold_gap_cs2", {30'd0, spi_cs_n}, 32'h2);
      cs_release = 1'b1;
      @(posedge clk); #1;
      cs_release = 1'b0;
      check("release_cs", {30'd0, spi_cs_n}, 32'h3);

      // Re-hold, then start together with release: start wins, CS stays low.
      run_xfer(v, 1'b0, 1'b0);
      v.data = 8'h81; v.exp_rx = 8'h81;
      run_xfer(v, 1'b0, 1'b1);
      check("start_beats_release", {30'd0, spi_cs_n}, 32'h2);

      // Held CS0 handed over to CS1 on accept.
      v = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h5C, 2'd0, 1'b1, 8'h5C, 19};
      run_xfer(v, 1'b0, 1'b0);

      // Reset in the middle of a transfer.
      cpol = 1'b1; cpha = 1'b0; divider = 5'd1; data_tx = 8'hFF; cs_sel = 1'b0;
      hold_cs = 1'b1; miso_mode = 2'd1;
      @(posedge clk); #1;
      txn_start = 1'b1;
      @(posedge clk); #1;
      txn_start = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd1);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_cs", {30'd0, spi_cs_n}, 32'h3);
      check("abort_busy_off", {31'd0, busy}, 32'd0);
      check("abort_clk", {31'd0, spi_clk}, 32'd0);
      check("abort_mosi", {31'd0, spi_mosi}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort_ready", {31'd0, txn_ready}, 32'd1);
      repeat (50) @(posedge clk);
      #1;
      check("abort_idle_busy", {31'd0, busy}, 32'd0);

      // 16-bit instance, out-of-range chip select.
      d2_divider = 5'd0; d2_cs_sel = 2'd3; d2_tx = 16'hBEEF;
      @(posedge clk); #1;
      d2_start = 1'b1;
      @(posedge clk); #1;
      d2_start = 1'b0;
      check("d2_busy", {31'd0, d2_busy}, 32'd1);
      steps = 1; toggles = 0; prev = 1'b0; cs_ok = 1'b1;
      while (d2_valid !== 1'b1 && steps < 200) begin
         if (d2_cs_n !== 3'b111) cs_ok = 1'b0;
         if (d2_clk !== prev) begin
            toggles++;
            prev = d2_clk;
         end
         @(posedge clk); #1;
         steps++;
      end
      check("d2_latency", steps, 32'd35);
      check("d2_toggles", toggles, 32'd32);
      check("d2_cs_none", {31'd0, cs_ok}, 32'd1);
      check("d2_rx", {16'd0, d2_rx}, 32'hBEEF);
      check("d2_cs_after", {29'd0, d2_cs_n}, 32'h7);
      check("d2_ready", {31'd0, d2_ready}, 32'd1);

      repeat (5) @(posedge clk);
      #1;
      check("sb_empty", sbq.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
